multifunc_unit: RTL and testbench

MULTIFUNC_UNIT -- requirements
Module: multifunc_unit

---
 rtl/multifunc_unit.sv | 165 ++++++++++++++++
 tb/tb_multifunc_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multifunc_unit.sv
// multifunc_unit: one-shot invert / counter snapshot / parity operations,
// an iterative shift-and-add multiplier, and a free-running counter.
module multifunc_unit #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               hold,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] q,
  output logic               busy,
  output logic               done
);

  localparam int QW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [QW-1:0]    r_ctr;
  logic [QW-1:0]    r_q;
  logic [QW-1:0]    w_q_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [QW-1:0]    r_acc;
  logic [QW-1:0]    w_acc_nxt;
  logic [QW-1:0]    r_mcand;
  logic [QW-1:0]    w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [IW-1:0]    r_iter;
  logic [IW-1:0]    w_iter_nxt;
  logic [QW-1:0]    w_addend;
  logic [QW-1:0]    w_acc_sum;
  logic             w_last;

  // Parity of the operand, flipped when odd parity is selected.
  function automatic logic parity_bit(input logic [WIDTH-1:0] v);
    return (^v) ^ PARITY_ODD;
  endfunction

  assign w_addend  = r_mplier[0] ? r_mcand : {QW{1'b0}};
  assign w_acc_sum = r_acc + w_addend;
  assign w_last    = (r_iter == IW'(WIDTH - 1));

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

  // Free-running counter: counts every edge unless frozen by hold; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr <= {QW{1'b0}};
    end else if (!hold) begin
      r_ctr <= r_ctr + {{(QW-1){1'b0}}, 1'b1};
    end else begin
      r_ctr <= r_ctr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode: accepts start only in IDLE, one multiply step per MUL edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_iter_nxt   = r_iter;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            2'b00: begin
              w_q_nxt    = {~A, ~B};
              w_done_nxt = 1'b1;
            end
            2'b01: begin
              w_q_nxt    = r_ctr;
              w_done_nxt = 1'b1;
            end
            2'b10: begin
              w_state_nxt  = ST_MUL;
              w_acc_nxt    = {QW{1'b0}};
              w_iter_nxt   = {IW{1'b0}};
              w_busy_nxt   = 1'b1;
              w_mcand_nxt  = {{WIDTH{1'b0}}, B};
              w_mplier_nxt = A;
            end
            2'b11: begin
              w_q_nxt    = {{(QW-1){1'b0}}, parity_bit(B)};
              w_done_nxt = 1'b1;
            end
            default: begin
              w_state_nxt = ST_IDLE;
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_acc_nxt    = w_acc_sum;
        w_mcand_nxt  = {r_mcand[QW-2:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
        w_iter_nxt   = r_iter + IW'(1);
        if (w_last) begin
          w_q_nxt     = w_acc_sum;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Result, status and multiplier working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= {QW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= {QW{1'b0}};
      r_mcand  <= {QW{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_iter   <= {IW{1'b0}};
    end else begin
      r_q      <= w_q_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_iter   <= w_iter_nxt;
    end
  end

endmodule

// File: tb/tb_multifunc_unit.sv
// Self-checking bench for multifunc_unit: an 8-bit instance tracked cycle by
// cycle against a behavioural model, a 16-bit odd-parity instance for the
// random multiply regression, and a 4-bit instance for counter wrap-around.
module tb_multifunc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 8-bit instance
  logic        rst8 = 1'b1, start8 = 1'b0, hold8 = 1'b0;
  logic [1:0]  op8 = 2'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic [15:0] q8;
  logic        busy8, done8;

  // 16-bit odd-parity instance
  logic        rst16 = 1'b1, start16 = 1'b0, hold16 = 1'b0;
  logic [1:0]  op16 = 2'd0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic [31:0] q16;
  logic        busy16, done16;

  // 4-bit instance
  logic        rst4 = 1'b1, start4 = 1'b0, hold4 = 1'b0;
  logic [1:0]  op4 = 2'd0;
  logic [3:0]  a4 = 4'd0, b4 = 4'd0;
  logic [7:0]  q4;
  logic        busy4, done4;

  multifunc_unit #(.WIDTH(8), .PARITY_ODD(1'b0)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .hold(hold8),
    .A(a8), .B(b8), .q(q8), .busy(busy8), .done(done8));

  multifunc_unit #(.WIDTH(16), .PARITY_ODD(1'b1)) u16 (
    .clk(clk), .rst(rst16), .start(start16), .op(op16), .hold(hold16),
    .A(a16), .B(b16), .q(q16), .busy(busy16), .done(done16));

  multifunc_unit #(.WIDTH(4), .PARITY_ODD(1'b0)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .op(op4), .hold(hold4),
    .A(a4), .B(b4), .q(q4), .busy(busy4), .done(done4));

  // Behavioural model of the 8-bit instance: counter as an integer, the
  // multiply as a product plus a count of edges left until it is delivered.
  int unsigned m_ctr  = 0;
  logic [15:0] m_q    = 16'd0;
  logic [15:0] m_prod = 16'd0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  bit          chk_en = 1'b0;

  // Model update on each rising edge from the inputs sampled at that edge.
  always @(posedge clk) begin
    if (rst8) begin
      m_ctr = 0; m_q = 16'd0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_q = m_prod; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start8) begin
        case (op8)
          2'd0:    begin m_q = {~a8, ~b8}; m_done = 1'b1; end
          2'd1:    begin m_q = 16'(m_ctr); m_done = 1'b1; end
          2'd2:    begin m_prod = 16'(a8) * 16'(b8); m_left = 8; m_busy = 1'b1; end
          default: begin m_q = {15'd0, ^b8}; m_done = 1'b1; end
        endcase
      end
      if (!hold8) m_ctr = (m_ctr + 1) % 65536;
    end
  end

  // Per-cycle comparison of the 8-bit instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (q8 !== m_q || busy8 !== m_busy || done8 !== m_done) begin
        n_err++;
        $display("FAIL model_cmp t=%0t actual q=%h busy=%b done=%b required q=%h busy=%b done=%b",
                 $time, q8, busy8, done8, m_q, m_busy, m_done);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Multiply on the 8-bit instance; inputs are scrambled right after acceptance.
  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string nm);
    int cycles;
    int nbusy;
    a8 = a; b8 = b; op8 = 2'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    cycles = 0; nbusy = 0;
    while (done8 !== 1'b1 && cycles < 20) begin
      if (busy8 === 1'b1) nbusy++;
      tick();
      cycles++;
    end
    chk({nm, "_latency"}, 32'(cycles), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(nbusy), 32'd8);
    chk({nm, "_q"}, {16'd0, q8}, {16'd0, exp});
    chk({nm, "_busy_after"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit seen;
    logic [31:0] exp;

    // Reset, with a start asserted alongside rst that must be ignored.
    rst8 = 1'b1; start8 = 1'b1; op8 = 2'd0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_q", {16'd0, q8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);

    // Counter: 5 counting edges, 3 held edges, then snapshot.
    rst8 = 1'b0; start8 = 1'b0; hold8 = 1'b0;
    repeat (5) tick();
    hold8 = 1'b1;
    repeat (3) tick();
    op8 = 2'd1; start8 = 1'b1;
    tick();
    start8 = 1'b0; hold8 = 1'b0;
    chk("snapshot_q", {16'd0, q8}, 32'h0000_0005);
    chk("snapshot_done", {31'd0, done8}, 32'd1);

    // Invert, then one-cycle done and q hold.
    a8 = 8'h0F; b8 = 8'hF0; op8 = 2'd0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("invert_q", {16'd0, q8}, 32'h0000_F00F);
    chk("invert_done", {31'd0, done8}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, done8}, 32'd0);
    chk("q_held", {16'd0, q8}, 32'h0000_F00F);

    // Even parity.
    b8 = 8'h07; op8 = 2'd3; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("parity_even_q", {16'd0, q8}, 32'h0000_0001);

    // Multiplies.
    mul8(8'd13, 8'd11, 16'h008F, "mul_13x11");
    mul8(8'd255, 8'd255, 16'hFE01, "mul_255x255");

    // Start during MUL is dropped; start on the done cycle is taken.
    a8 = 8'd3; b8 = 8'd5; op8 = 2'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (2) tick();
    op8 = 2'd0; a8 = 8'h55; b8 = 8'hAA; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cycles = 0;
    while (done8 !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("ignored_start_q", {16'd0, q8}, 32'h0000_000F);
    a8 = 8'h0F; b8 = 8'hF0; op8 = 2'd0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("b2b_q", {16'd0, q8}, 32'h0000_F00F);
    chk("b2b_done", {31'd0, done8}, 32'd1);

    // Reset on the 4th MUL cycle aborts the multiply with no done pulse.
    a8 = 8'd200; b8 = 8'd100; op8 = 2'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    chk("abort_q", {16'd0, q8}, 32'd0);
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (done8 === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);

    // Random traffic on the 8-bit instance, checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      rst8   = ($urandom_range(0, 49) == 0);
      start8 = 1'($urandom_range(0, 1));
      op8    = 2'($urandom_range(0, 3));
      hold8  = 1'($urandom_range(0, 1));
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      tick();
    end
    rst8 = 1'b0; start8 = 1'b0; hold8 = 1'b0;
    repeat (10) tick();

    // 16-bit instance: odd parity, then random multiply regression.
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    b16 = 16'h0007; op16 = 2'd3; start16 = 1'b1;
    tick();
    chk("parity_odd_7", q16, 32'h0000_0000);
    b16 = 16'h0003;
    tick();
    start16 = 1'b0;
    chk("parity_odd_3", q16, 32'h0000_0001);
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
      exp = 32'(a16) * 32'(b16);
      op16 = 2'd2; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      cycles = 0;
      while (done16 !== 1'b1 && cycles < 40) begin
        tick();
        cycles++;
      end
      chk("mul16_latency", 32'(cycles), 32'd16);
      chk("mul16_q", q16, exp);
    end
    chk("mul16_ffff_sq_pin", 32'hFFFF * 32'hFFFF, 32'hFFFE_0001);

    // 4-bit instance: 8-bit counter reaches all-ones, then wraps to zero.
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0; hold4 = 1'b0;
    repeat (255) tick();
    hold4 = 1'b1; op4 = 2'd1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ctr_allones", {24'd0, q4}, 32'h0000_00FF);
    hold4 = 1'b0;
    tick();
    hold4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ctr_wrap", {24'd0, q4}, 32'h0000_0000);
    chk("ctr_wrap_done", {31'd0, done4}, 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
